// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// The funct3 encodings and their signedness rules live here so every file agrees.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int CNTW_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

  // mulhsu is the only op whose operands differ in signedness
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request/response bundle between the pipeline and the M-extension unit.
interface muldiv_if import muldiv_pkg::*; #(
  parameter int XLEN = XLEN_DEF
);
  logic            StartE;
  logic [2:0]      MdOpE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            FlushE;
  logic            StallMD;
  logic            BusyE;
  logic            MdDoneE;
  logic [XLEN-1:0] MdResultE;

  modport master (
    output StartE, MdOpE, SrcAE, SrcBE, FlushE,
    input  StallMD, BusyE, MdDoneE, MdResultE
  );

  modport slave (
    input  StartE, MdOpE, SrcAE, SrcBE, FlushE,
    output StallMD, BusyE, MdDoneE, MdResultE
  );
endinterface

// File: rtl/muldiv_dp.sv
// Radix-2 iterative datapath: shift-add multiply and restoring divide on operand
// magnitudes, with one shared adder/subtractor and sign fix-up into the result register.
module muldiv_dp import muldiv_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            finish,
  input  logic            spec_load,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [XLEN-1:0] spec_val,
  output logic [XLEN-1:0] result
);

  logic [2:0]      op_reg;
  logic            neg_reg;
  logic [XLEN-1:0] opnd_reg;
  logic [XLEN-1:0] acc_reg;
  logic [XLEN-1:0] sh_reg;
  logic [XLEN-1:0] result_reg;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  logic            div_mode;
  logic [XLEN:0]   add_x, add_y;
  logic [XLEN+1:0] add_sum;
  logic [XLEN-1:0] acc_next, sh_next;

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, result_next;

  assign a_neg = op_a_signed(op) & src_a[XLEN-1];
  assign b_neg = op_b_signed(op) & src_b[XLEN-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;

  // Divide: opnd holds the divisor, sh shifts the dividend out and the quotient in.
  // Multiply: opnd holds the multiplicand, sh shifts the multiplier out and the low product in.
  assign div_mode = op_is_div(op_reg);
  assign add_x    = div_mode ? {acc_reg, sh_reg[XLEN-1]} : {1'b0, acc_reg};
  assign add_y    = {1'b0, opnd_reg};
  assign add_sum  = {1'b0, add_x} + {1'b0, (div_mode ? ~add_y : add_y)}
                  + {{(XLEN+1){1'b0}}, div_mode};

  always_comb begin
    acc_next = acc_reg;
    sh_next  = sh_reg;
    if (div_mode) begin
      // top carry set means the trial subtraction did not borrow
      acc_next = add_sum[XLEN+1] ? add_sum[XLEN-1:0] : add_x[XLEN-1:0];
      sh_next  = {sh_reg[XLEN-2:0], add_sum[XLEN+1]};
    end else if (sh_reg[0]) begin
      acc_next = add_sum[XLEN:1];
      sh_next  = {add_sum[0], sh_reg[XLEN-1:1]};
    end else begin
      acc_next = {1'b0, acc_reg[XLEN-1:1]};
      sh_next  = {acc_reg[0], sh_reg[XLEN-1:1]};
    end
  end

  // Result is taken from the post-step values so the final step and the fix-up share one edge
  assign prod     = {acc_next, sh_next};
  assign prod_fix = neg_reg ? -prod : prod;
  assign quot_fix = neg_reg ? -sh_next : sh_next;
  assign rem_fix  = neg_reg ? -acc_next : acc_next;

  always_comb begin
    result_next = rem_fix;
    case (op_reg)
      MD_MUL:                       result_next = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_next = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result_next = quot_fix;
      default:                      result_next = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= '0;
      neg_reg    <= 1'b0;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      sh_reg     <= '0;
      result_reg <= '0;
    end else begin
      if (load) begin
        op_reg   <= op;
        neg_reg  <= op_is_rem(op) ? a_neg : (a_neg ^ b_neg);
        opnd_reg <= op_is_div(op) ? b_mag : a_mag;
        sh_reg   <= op_is_div(op) ? a_mag : b_mag;
        acc_reg  <= '0;
      end else if (step) begin
        acc_reg  <= acc_next;
        sh_reg   <= sh_next;
      end
      if (spec_load) begin
        result_reg <= spec_val;
      end else if (finish) begin
        result_reg <= result_next;
      end
    end
  end

  assign result = result_reg;

endmodule

// File: rtl/muldiv_ctrl.sv
// M-extension sequencer: IDLE/CALC/DONE FSM, iteration counter, divide special-case
// short-cut and the pipeline stall, driving the muldiv_dp datapath.
module muldiv_ctrl import muldiv_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave md
);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t       state_reg, state_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;

  logic            accept;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] spec_val;
  logic            dp_load, dp_step, dp_finish, dp_spec;
  logic [XLEN-1:0] dp_result;

  assign accept   = md.StartE & ~md.FlushE;
  assign div_zero = op_is_div(md.MdOpE) && (md.SrcBE == '0);
  assign div_ovf  = op_is_div(md.MdOpE) && op_b_signed(md.MdOpE) &&
                    (md.SrcAE == INT_MIN) && (md.SrcBE == '1);
  assign special  = div_zero | div_ovf;

  // Both short-cut results are fixed by the ISA and need no iteration
  always_comb begin
    spec_val = '0;
    if (div_zero) begin
      spec_val = op_is_rem(md.MdOpE) ? md.SrcAE : '1;
    end else begin
      spec_val = op_is_rem(md.MdOpE) ? '0 : md.SrcAE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dp_load    = 1'b0;
    dp_step    = 1'b0;
    dp_finish  = 1'b0;
    dp_spec    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          dp_load  = 1'b1;
          cnt_next = '0;
          if (special) begin
            dp_spec    = 1'b1;
            state_next = ST_DONE;
          end else begin
            state_next = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (md.FlushE) begin
          state_next = ST_IDLE;
        end else begin
          dp_step  = 1'b1;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            dp_finish  = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  muldiv_dp #(.XLEN(XLEN)) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dp_load),
    .step     (dp_step),
    .finish   (dp_finish),
    .spec_load(dp_spec),
    .op       (md.MdOpE),
    .src_a    (md.SrcAE),
    .src_b    (md.SrcBE),
    .spec_val (spec_val),
    .result   (dp_result)
  );

  // Stall drops in DONE so the instruction leaves Execute with its result
  assign md.StallMD   = ((state_reg == ST_IDLE) && accept) || (state_reg == ST_CALC);
  assign md.BusyE     = (state_reg == ST_CALC) || (state_reg == ST_DONE);
  assign md.MdDoneE   = (state_reg == ST_DONE);
  assign md.MdResultE = dp_result;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed ISA cases, randomized ops against an
// arithmetic reference, flush/reset aborts and ignored StartE while busy.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) md ();

  muldiv_ctrl #(.XLEN(32), .CNTW(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .md   (md)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_res = '0;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [5:0]  lat;
  } vec_t;

  // Plain integer arithmetic of the ISA definition, including the divide corner cases
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (op)
      3'b000: begin p = sa * sb; r = p[31:0]; end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * ub; r = p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'b100: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'b101: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else r = a / b;
      end
      3'b110: begin
        if (b == 0) r = a;
        else if (ovf) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else r = a % b;
      end
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0)) return 1;
    if ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op and wait (bounded) for MdDoneE; cycle 0 is the cycle StartE is high
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int stall_err);
    stall_err = 0;
    lat = -1;
    res = '0;
    @(negedge clk);
    md.StartE = 1'b1; md.FlushE = 1'b0;
    md.MdOpE = op; md.SrcAE = a; md.SrcBE = b;
    #1;
    if (md.StallMD !== 1'b1) stall_err++;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      md.StartE = 1'b0;
      md.SrcAE = $urandom; md.SrcBE = $urandom; md.MdOpE = 3'($urandom);
      #1;
      if (md.MdDoneE === 1'b1) begin
        lat = c;
        res = md.MdResultE;
        if (md.StallMD !== 1'b0) stall_err++;
        last_res = res;
        break;
      end
      if (md.StallMD !== 1'b1) stall_err++;
    end
    $display("op=%0d a=%h b=%h result=%h latency=%0d", op, a, b, res, lat);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_cmp++; if (md.MdDoneE !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", md.MdDoneE); end
    n_cmp++; if (md.BusyE !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", md.BusyE); end
    n_cmp++; if (md.MdResultE !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h expected 0", md.MdResultE); end
    n_cmp++; if (md.StallMD !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", md.StallMD); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (md.BusyE !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy: got %b expected 0", md.BusyE); end
  endtask

  task automatic test_directed();
    vec_t vecs [10];
    logic [31:0] res;
    int lat, serr;
    vecs[0] = '{MD_MUL,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 6'd33};
    vecs[1] = '{MD_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 6'd33};
    vecs[2] = '{MD_MULH,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 6'd33};
    vecs[3] = '{MD_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 6'd33};
    vecs[4] = '{MD_REM,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 6'd33};
    vecs[5] = '{MD_DIVU,  32'd100,        32'd7,         32'd14,        6'd33};
    vecs[6] = '{MD_REMU,  32'd100,        32'd7,         32'd2,         6'd33};
    vecs[7] = '{MD_DIVU,  32'd5,          32'd0,         32'hFFFF_FFFF, 6'd1};
    vecs[8] = '{MD_REM,   32'd5,          32'd0,         32'd5,         6'd1};
    vecs[9] = '{MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 6'd1};
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, serr);
      n_cmp++; if (res !== vecs[i].exp) begin n_bad++; $display("FAIL directed[%0d]_result: got %h expected %h", i, res, vecs[i].exp); end
      n_cmp++; if (lat != int'(vecs[i].lat)) begin n_bad++; $display("FAIL directed[%0d]_latency: got %0d expected %0d", i, lat, vecs[i].lat); end
      n_cmp++; if (serr != 0) begin n_bad++; $display("FAIL directed[%0d]_stall: got %0d bad cycles expected 0", i, serr); end
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [31:0] a, b, exp, res;
    int lat, serr, sel;
    for (int i = 0; i < 30; i++) begin
      op  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      a = $urandom; b = $urandom;
      if (sel == 0) b = 32'h0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
      else if (sel == 3) begin a = -$urandom_range(0, 300); b = $urandom_range(1, 20); end
      exp = ref_md(op, a, b);
      do_op(op, a, b, res, lat, serr);
      n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL random[%0d]_result op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, res, exp); end
      n_cmp++; if (lat != ref_lat(op, a, b)) begin n_bad++; $display("FAIL random[%0d]_latency: got %0d expected %0d", i, lat, ref_lat(op, a, b)); end
      n_cmp++; if (serr != 0) begin n_bad++; $display("FAIL random[%0d]_stall: got %0d bad cycles expected 0", i, serr); end
      @(negedge clk);
      #1;
      n_cmp++; if (md.MdDoneE !== 1'b0 || md.BusyE !== 1'b0) begin n_bad++; $display("FAIL random[%0d]_pulse: done=%b busy=%b expected 0 0", i, md.MdDoneE, md.BusyE); end
      n_cmp++; if (md.MdResultE !== exp) begin n_bad++; $display("FAIL random[%0d]_hold: got %h expected %h", i, md.MdResultE, exp); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, a, b, res;
    int lat, serr, early, dones;
    prev = last_res;
    early = 0;
    dones = 0;
    @(negedge clk);
    md.StartE = 1'b1; md.FlushE = 1'b0; md.MdOpE = MD_MULHU; md.SrcAE = $urandom; md.SrcBE = $urandom;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      md.StartE = 1'b0;
      md.FlushE = (c == 10);
      #1;
      if (md.MdDoneE !== 1'b0 || md.BusyE !== 1'b1) early++;
    end
    @(negedge clk);
    md.FlushE = 1'b0;
    #1;
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL flush_calc_busy: got %0d bad cycles expected 0", early); end
    n_cmp++; if (md.BusyE !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b expected 0", md.BusyE); end
    n_cmp++; if (md.StallMD !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b expected 0", md.StallMD); end
    n_cmp++; if (md.MdResultE !== prev) begin n_bad++; $display("FAIL flush_result_hold: got %h expected %h", md.MdResultE, prev); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (md.MdDoneE === 1'b1) dones++;
    end
    n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL flush_no_done: got %0d pulses expected 0", dones); end
    a = $urandom; b = $urandom_range(1, 1000);
    do_op(MD_DIV, a, b, res, lat, serr);
    n_cmp++; if (res !== ref_md(MD_DIV, a, b)) begin n_bad++; $display("FAIL flush_restart_result: got %h expected %h", res, ref_md(MD_DIV, a, b)); end
    n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL flush_restart_latency: got %0d expected 33", lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res, a, b;
    int lat, serr, dones, busy;
    dones = 0;
    busy = 0;
    do_op(MD_MUL, 32'd7, 32'hFFFF_FFFD, res, lat, serr);
    @(negedge clk);
    md.StartE = 1'b1; md.FlushE = 1'b0; md.MdOpE = MD_REMU; md.SrcAE = $urandom; md.SrcBE = 32'd3;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      md.StartE = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (md.MdDoneE !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b expected 0", md.MdDoneE); end
    n_cmp++; if (md.BusyE !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", md.BusyE); end
    n_cmp++; if (md.StallMD !== 1'b0) begin n_bad++; $display("FAIL rstmid_stall: got %b expected 0", md.StallMD); end
    n_cmp++; if (md.MdResultE !== 32'h0) begin n_bad++; $display("FAIL rstmid_result: got %h expected 0", md.MdResultE); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (md.MdDoneE === 1'b1) dones++;
      if (md.BusyE === 1'b1) busy++;
    end
    n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", dones); end
    n_cmp++; if (busy != 0) begin n_bad++; $display("FAIL rstmid_idle: got %0d busy cycles expected 0", busy); end
    a = $urandom; b = $urandom;
    do_op(MD_MULHSU, a, b, res, lat, serr);
    n_cmp++; if (res !== ref_md(MD_MULHSU, a, b)) begin n_bad++; $display("FAIL rstmid_restart_result: got %h expected %h", res, ref_md(MD_MULHSU, a, b)); end
  endtask

  task automatic test_start_ignored();
    logic [31:0] a, b, exp, got;
    int lat;
    lat = -1;
    got = '0;
    a = $urandom; b = $urandom_range(1, 50000);
    exp = ref_md(MD_DIVU, a, b);
    @(negedge clk);
    md.StartE = 1'b1; md.FlushE = 1'b0; md.MdOpE = MD_DIVU; md.SrcAE = a; md.SrcBE = b;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      // restart attempts mid-CALC and a start+flush on the DONE cycle must all be ignored
      md.StartE = (c == 5) || (c == 17) || (c == 33);
      md.FlushE = (c == 33);
      md.MdOpE = MD_MUL; md.SrcAE = $urandom; md.SrcBE = $urandom;
      #1;
      if (md.MdDoneE === 1'b1) begin lat = c; got = md.MdResultE; break; end
    end
    @(negedge clk);
    md.StartE = 1'b0; md.FlushE = 1'b0;
    #1;
    $display("op=%0d a=%h b=%h result=%h latency=%0d", MD_DIVU, a, b, got, lat);
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL start_ignored_result: got %h expected %h", got, exp); end
    n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL start_ignored_latency: got %0d expected 33", lat); end
    n_cmp++; if (md.BusyE !== 1'b0) begin n_bad++; $display("FAIL start_ignored_idle: got %b expected 0", md.BusyE); end
    n_cmp++; if (md.MdResultE !== exp) begin n_bad++; $display("FAIL start_ignored_hold: got %h expected %h", md.MdResultE, exp); end
  endtask

  task automatic test_start_flush_idle();
    @(negedge clk);
    md.StartE = 1'b1; md.FlushE = 1'b1; md.MdOpE = MD_MUL; md.SrcAE = $urandom; md.SrcBE = $urandom;
    #1;
    n_cmp++; if (md.StallMD !== 1'b0) begin n_bad++; $display("FAIL idle_startflush_stall: got %b expected 0", md.StallMD); end
    @(negedge clk);
    md.StartE = 1'b0; md.FlushE = 1'b0;
    #1;
    n_cmp++; if (md.BusyE !== 1'b0 || md.MdDoneE !== 1'b0) begin n_bad++; $display("FAIL idle_startflush_state: busy=%b done=%b expected 0 0", md.BusyE, md.MdDoneE); end
  endtask

  initial begin
    md.StartE = 1'b0;
    md.FlushE = 1'b0;
    md.MdOpE  = 3'b000;
    md.SrcAE  = '0;
    md.SrcBE  = '0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_start_ignored();
    test_start_flush_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
